// File: rtl/input_buffer.sv
// Feature-map staging buffer: external memory writes one word per cycle into a
// selected bank; streams full rows (one word from every bank) to the PE array.
module input_buffer #(
   parameter int WORD_W     = 16,
   parameter int NUM_BANKS  = 32,
   parameter int BANK_IDX_W = 6,
   parameter int ADDR_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        loading_ext_mem,
   input  logic                        ext_valid,
   output logic                        ext_ready,
   input  logic [BANK_IDX_W-1:0]       memory_bank_index,
   input  logic [ADDR_W-1:0]           memory_bank_address,
   input  logic [WORD_W-1:0]           ext_data,
   input  logic                        calc_PEA,
   input  logic [ADDR_W-1:0]           stream_base,
   input  logic [ADDR_W:0]             stream_len,
   output logic [NUM_BANKS*WORD_W-1:0] output_bus,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        bank_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int ROW_W = NUM_BANKS * WORD_W;
   localparam int LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM
   } state_e;

   state_e state_q, state_d;

   // Bank storage and the registered row read out of it.
   logic [WORD_W-1:0] bank_mem [NUM_BANKS][DEPTH];
   logic [ROW_W-1:0]  rd_row_q;

   // Read issue side.
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]  issue_left_q, issue_left_d;
   logic              rd_pend_q, rd_pend_d;

   // Transfer side: output register plus one skid entry.
   logic [LEN_W-1:0]  xfer_left_q, xfer_left_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ROW_W-1:0]  skid_row_q, skid_row_d;
   logic              out_valid_q, out_valid_d;
   logic [ROW_W-1:0]  out_row_q, out_row_d;

   logic done_q, done_d;
   logic bank_err_q, bank_err_d;

   logic       wr_acc;
   logic       bank_ok;
   logic       start;
   logic       xfer;
   logic       out_free;
   logic       stream_end;
   logic       rd_en;
   logic [1:0] occ;

   assign wr_acc     = ext_valid && ext_ready;
   assign bank_ok    = int'(memory_bank_index) < NUM_BANKS;
   assign start      = (state_q == S_IDLE) && !loading_ext_mem && calc_PEA;
   assign xfer       = out_valid_q && out_ready;
   assign out_free   = !out_valid_q || xfer;
   assign stream_end = (xfer_left_q == '0) || (xfer && (xfer_left_q == LEN_W'(1)));

   // Rows in flight or held; a new read is issued only if it still fits in
   // the output register plus skid entry once this cycle's transfer is taken.
   assign occ   = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
   assign rd_en = (state_q == S_STREAM) && (issue_left_q != '0) &&
                  ((occ - {1'b0, xfer}) < 2'd2);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (loading_ext_mem) begin
               state_d = S_LOAD;
            end else if (calc_PEA) begin
               state_d = S_STREAM;
            end
         end
         S_LOAD: begin
            if (!loading_ext_mem) begin
               state_d = S_IDLE;
            end
         end
         S_STREAM: begin
            if (stream_end) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ext_ready = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         S_LOAD:   begin ext_ready = loading_ext_mem; busy = 1'b1; end
         S_STREAM: busy = 1'b1;
         default:  ;
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_comb begin
      rd_addr_d    = rd_addr_q;
      issue_left_d = issue_left_q;
      xfer_left_d  = xfer_left_q;
      rd_pend_d    = rd_en;
      skid_valid_d = skid_valid_q;
      skid_row_d   = skid_row_q;
      out_valid_d  = out_valid_q;
      out_row_d    = out_row_q;
      done_d       = (state_q == S_STREAM) && stream_end;
      bank_err_d   = wr_acc && !bank_ok;

      if (start) begin
         rd_addr_d    = stream_base;
         issue_left_d = stream_len;
         xfer_left_d  = stream_len;
      end

      if (rd_en) begin
         rd_addr_d    = rd_addr_q + ADDR_W'(1);
         issue_left_d = issue_left_q - LEN_W'(1);
      end

      if (xfer) begin
         xfer_left_d = xfer_left_q - LEN_W'(1);
      end

      // The skid entry is always older than the row arriving from memory.
      if (out_free) begin
         if (skid_valid_q) begin
            out_row_d    = skid_row_q;
            out_valid_d  = 1'b1;
            skid_valid_d = rd_pend_q;
            if (rd_pend_q) begin
               skid_row_d = rd_row_q;
            end
         end else if (rd_pend_q) begin
            out_row_d   = rd_row_q;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (rd_pend_q) begin
         skid_row_d   = rd_row_q;
         skid_valid_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr_q    <= '0;
         issue_left_q <= '0;
         xfer_left_q  <= '0;
         rd_pend_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_row_q   <= '0;
         out_valid_q  <= 1'b0;
         out_row_q    <= '0;
         done_q       <= 1'b0;
         bank_err_q   <= 1'b0;
      end else begin
         rd_addr_q    <= rd_addr_d;
         issue_left_q <= issue_left_d;
         xfer_left_q  <= xfer_left_d;
         rd_pend_q    <= rd_pend_d;
         skid_valid_q <= skid_valid_d;
         skid_row_q   <= skid_row_d;
         out_valid_q  <= out_valid_d;
         out_row_q    <= out_row_d;
         done_q       <= done_d;
         bank_err_q   <= bank_err_d;
      end
   end

   // NOTE: the bank arrays and their read register are deliberately not reset;
   // contents must survive resets and a reset port would block RAM mapping.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (wr_acc && bank_ok && (int'(memory_bank_index) == b)) begin
            bank_mem[b][memory_bank_address] <= ext_data;
         end
         if (rd_en) begin
            rd_row_q[b*WORD_W +: WORD_W] <= bank_mem[b][rd_addr_q];
         end
      end
   end

   assign output_bus = out_row_q;
   assign out_valid  = out_valid_q;
   assign done       = done_q;
   assign bank_err   = bank_err_q;

endmodule

// File: doc/input_buffer.md
# input_buffer

Feature-map staging buffer between the external memory interface and the processing-element array (PEA): the inbound counterpart of `output_buffer`. In load mode it accepts one word per cycle from external memory into a selected bank/address. In calc mode it streams full rows (one word from every bank at a common address) onto a wide bus toward the PEA under a valid/ready handshake.

## Interface
- `WORD_W`, 16, bits per word per bank
- `NUM_BANKS`, 32, number of banks; row width = NUM_BANKS*WORD_W (512 by default)
- `BANK_IDX_W`, 6, width of bank index
- `ADDR_W`, 8, per-bank address width; depth 2^ADDR_W

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `loading_ext_mem`  in  1  level; requests/holds load mode
- `ext_valid`  in  1  external write word present
- `ext_ready`  out  1  buffer accepts a write this cycle
- `memory_bank_index`  in  BANK_IDX_W  target bank of write
- `memory_bank_address`  in  ADDR_W  target address of write
- `ext_data`  in  WORD_W  write data
- `calc_PEA`  in  1  pulse; start streaming
- `stream_base`  in  ADDR_W  first row address, sampled with `calc_PEA`
- `stream_len`  in  ADDR_W+1  row count, sampled with `calc_PEA`
- `output_bus`  out  NUM_BANKS*WORD_W  row to PEA; bank b at bits [b*WORD_W +: WORD_W]
- `out_valid`  out  1  `output_bus` holds a row
- `out_ready`  in  1  PEA accepts row
- `busy`  out  1  state is LOAD or STREAM
- `done`  out  1  one-cycle pulse at end of a stream
- `bank_err`  out  1  one-cycle pulse: accepted write had out-of-range bank index

## Operation
- FSM states: IDLE, LOAD, STREAM.
- IDLE: `loading_ext_mem`=1 -> LOAD; else `calc_PEA`=1 -> STREAM (load wins if both). `calc_PEA` is ignored outside IDLE.
- LOAD: `ext_ready` = `loading_ext_mem` (combinational, 0 in other states). Write accepted on `ext_valid & ext_ready`; word stored to bank `memory_bank_index`, address `memory_bank_address`. Index >= NUM_BANKS: write dropped, `bank_err` pulses the following cycle. `loading_ext_mem`=0 -> IDLE at that edge.
- STREAM: rows read at addresses `stream_base + i` for i = 0..stream_len-1, modulo 2^ADDR_W (wrap-around permitted). After the last row handshake -> IDLE and `done` pulses. `stream_len`=0: no `out_valid`, `done` pulses the cycle after the start, return to IDLE.
- Bank storage is not reset; contents persist across streams and resets.
- Rows are never lost, duplicated or reordered regardless of the `out_ready` pattern.

## Timing
- Reset values: `ext_ready`=0, `output_bus`=0, `out_valid`=0, `busy`=0, `done`=0, `bank_err`=0, state IDLE. Reset assertion mid-load or mid-stream aborts immediately; a pending row is discarded.
- Write-to-read: a word accepted at edge T is readable by a stream started at edge T+1 or later.
- Stream latency: `calc_PEA` sampled at edge T; first `out_valid` rises after edge T+2.
- Throughput: one row per cycle while `out_ready`=1.
- Handshake: while `out_valid`=1 and `out_ready`=0, `output_bus` and `out_valid` hold stable. A row transfers on `out_valid & out_ready`. Read prefetch of at most 2 rows (skid) is permitted.
- `done` is asserted in the cycle after the final transfer edge; `busy` falls at that same edge.
- `output_bus` retains the last transferred row when `out_valid`=0.

## Test plan
- Reset: drive `rst`=0 mid-stream -> all outputs 0 immediately; after release `busy`=0 and `calc_PEA` restarts cleanly.
- Load then stream: write word (b<<8)|a to every bank b, address a=0..3; `calc_PEA` with base 0, len 4, `out_ready`=1 -> 4 rows on consecutive cycles starting 2 cycles after start, row a lane b = (b<<8)|a; `done` pulses once after the 4th row.
- Backpressure: same data, toggle `out_ready` pseudo-randomly -> exactly 4 rows in order, bus stable while stalled.
- Wrap and zero length: base 254, len 4 -> addresses 254, 255, 0, 1. len 0 -> no `out_valid`, `done` one cycle after start.
- Bad index: write with `memory_bank_index`=40 -> `bank_err` pulse; memory unchanged, verified by a subsequent stream.
- Priority: `loading_ext_mem` and `calc_PEA` high together in IDLE -> enters LOAD, `ext_ready`=1, no stream output.
